inst_fetch_buffer: RTL and testbench
====================================

Name: inst_fetch_buffer

Overview:
- Decoupling buffer between PC generation and the decode stage for the SRAM-like instruction port.
- Issues up to MAX_OUT pipelined instruction requests and tags each with its PC.
- Buffers returned instructions in a DEPTH-entry FIFO and presents them to decode with valid/ready.
- On flush (exception commit, eret, branch redirect), all buffered entries are discarded, and the data_ok beats of already-accepted requests are silently dropped.

Parameters:
- DEPTH, 4: instruction FIFO entries; power of 2, ≥2.
- MAX_OUT, 2: maximum accepted-but-unreturned requests; power of 2, ≥1.
- AW, 32: PC / address width.
- DW, 32: instruction width.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- flush_i  in  1  discard all buffered and in-flight instructions this cycle.
- pc_valid_i  in  1  a fetch PC is offered.
- pc_i  in  AW  fetch PC (also driven onto inst_addr).
- pc_ready_o  out  1  PC accepted this cycle (equals inst_req && inst_addr_ok).
- inst_req  out  1  request to the instruction port.
- inst_addr  out  AW  request address.
- inst_addr_ok  in  1  port accepted the request.
- inst_rdata  in  DW  returned instruction.
- inst_data_ok  in  1  returned-data strobe, in request order.
- valid_o  out  1  FIFO head valid.
- pc_o  out  AW  PC of head.
- inst_o  out  DW  instruction of head.
- ready_i  in  1  decode consumes head when valid_o && ready_i.

Behaviour:
- Reset (async, resetn=0):
  - Output state: valid_o=0, inst_req=0, pc_ready_o=0, pc_o=0, inst_o=0.
  - Counters: FIFO count=0, outstanding=0, drop=0, all pointers=0.
  - Reset mid-transaction abandons everything; responses after reset are not expected.
- Credit rule:
  - credit = (fifo_count + outstanding + drop) < DEPTH, and (outstanding + drop) < MAX_OUT.
  - inst_req = pc_valid_i && credit && !flush_i (combinational).
  - inst_addr = pc_i.
- Issue: on inst_req && inst_addr_ok, push pc_i into the tag queue (MAX_OUT entries) and increment outstanding.
- Return: on inst_data_ok:
  - if drop>0: decrement drop; nothing enters the FIFO.
  - else: pop the tag queue, decrement outstanding, push {tag, inst_rdata} into the FIFO. The credit rule guarantees the FIFO is never full here.
- Output:
  - valid_o = fifo_count != 0; head is registered.
  - Latency data_ok → valid_o is 1 cycle.
  - Pop on valid_o && ready_i.
- Simultaneous push and pop: count unchanged, both pointers advance. Pointers wrap modulo DEPTH / MAX_OUT.
- Flush (flush_i=1), all applied next edge:
  - FIFO count := 0, tag queue cleared, valid_o := 0.
  - drop := drop + outstanding − (inst_data_ok ? 1 : 0), so a beat arriving in the flush cycle is dropped.
  - outstanding := 0.
  - No new request is issued in the flush cycle; a pop attempted in that cycle is ignored.
- Back-to-back flushes accumulate drop correctly; drop never exceeds MAX_OUT.
- Interface assumption violation: inst_data_ok with outstanding=0 and drop=0 is an error. Flag it with a simulation-only assertion; the RTL ignores the beat.
- Counter widths: fifo_count is $clog2(DEPTH)+1 bits; outstanding and drop are $clog2(MAX_OUT)+1 bits.

Optional Feature:
- Macro: FETCH_BUF_BYPASS_EN.
- Defined:
  - When the FIFO is empty, drop=0, flush_i=0 and inst_data_ok=1, the head outputs are driven combinationally from {tag head, inst_rdata} with valid_o=1 in the same cycle.
  - If ready_i=1 in that cycle, the beat is consumed and not written to the FIFO; otherwise it is written normally.
  - Latency data_ok → valid_o is 0 cycles.
- Undefined: all outputs registered; latency is 1 cycle as above.

Test Plan:
- Streaming:
  - Stimulus: pc_valid_i=1, PCs 0xBFC00000, +4, +8…; addr_ok always 1; data_ok one cycle after each accept; ready_i=1.
  - Response: valid_o stream in order with matching pc_o/inst_o; outstanding never exceeds 2.
- Backpressure:
  - Stimulus: ready_i=0 for 10 cycles.
  - Response: FIFO fills to 4, inst_req drops to 0 once count+outstanding=4; no beat lost after release.
- Flush with 2 outstanding:
  - Stimulus: flush_i pulse, then 2 stale data_ok beats (0xDEAD0001/2), then a new request at 0xBFC00380 returning 0x12345678.
  - Response: stale beats never appear; first valid_o has pc_o=0xBFC00380, inst_o=0x12345678.
- Flush coinciding with data_ok and pop:
  - Stimulus: flush_i, inst_data_ok and ready_i in the same cycle, outstanding=2.
  - Response: drop=1 afterward, valid_o=0 next cycle.
- Async reset mid-stream:
  - Stimulus: resetn low between clock edges with FIFO count 3.
  - Response: valid_o=0 and inst_req=0 immediately; all counters zero.
- With FETCH_BUF_BYPASS_EN defined:
  - Stimulus: FIFO empty, data_ok with ready_i=1.
  - Response: valid_o=1 in the same cycle; FIFO count stays 0.

Source files
------------

// File: rtl/inst_fetch_buffer.sv
// -----------------------------------------------------------------------------
// inst_fetch_buffer
//
// Decouples PC generation from decode on an SRAM-like instruction port.
// Up to MAX_OUT requests may be in flight; each accepted request remembers its
// PC in a small tag queue. Returned instructions land in a DEPTH-entry FIFO and
// are offered to decode with valid/ready. A flush empties the FIFO and turns
// every in-flight request into a "drop" credit, so the data beats of those
// requests are swallowed when they eventually return.
//
// Optional feature: define FETCH_BUF_BYPASS_EN to present a returning beat
// to decode in the same cycle when the FIFO is empty (zero-cycle latency).
// Without it, every head output comes from flops (one-cycle latency).
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   flush_i            discard all buffered and in-flight instructions
//   pc_valid_i, pc_i   fetch PC offered by PC generation
//   pc_ready_o         PC accepted this cycle (inst_req && inst_addr_ok)
//   inst_req           request to the instruction port
//   inst_addr          request address (= pc_i)
//   inst_addr_ok       port accepted the request
//   inst_rdata         returned instruction
//   inst_data_ok       returned-data strobe, in request order
//   valid_o            FIFO head valid
//   pc_o, inst_o       head PC / instruction
//   ready_i            decode consumes head when valid_o && ready_i
// -----------------------------------------------------------------------------
module inst_fetch_buffer #(
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          flush_i,
    input  logic          pc_valid_i,
    input  logic [AW-1:0] pc_i,
    output logic          pc_ready_o,
    output logic          inst_req,
    output logic [AW-1:0] inst_addr,
    input  logic          inst_addr_ok,
    input  logic [DW-1:0] inst_rdata,
    input  logic          inst_data_ok,
    output logic          valid_o,
    output logic [AW-1:0] pc_o,
    output logic [DW-1:0] inst_o,
    input  logic          ready_i
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int OW = $clog2(MAX_OUT) + 1;

    logic [AW-1:0] fifo_pc   [DEPTH];
    logic [DW-1:0] fifo_inst [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] fifo_count;

    logic [AW-1:0] tag_mem [MAX_OUT];
    logic [TW-1:0] tag_wr, tag_rd;
    logic [OW-1:0] outstanding, drop;

    logic [31:0] inflight_sum, total_sum;
    logic        credit, issue;
    logic        take_beat, drop_beat, flush_beat;
    logic        fifo_vld, fifo_push, head_pop;

    // Tag-queue pointer advance; explicit wrap keeps MAX_OUT == 1 correct.
    function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
        if (p == TW'(MAX_OUT - 1))
            return '0;
        return p + TW'(1);
    endfunction

    // Dropped beats still occupy the port, so they count against both limits.
    assign inflight_sum = 32'(outstanding) + 32'(drop);
    assign total_sum    = 32'(fifo_count) + inflight_sum;
    assign credit       = (total_sum < 32'(DEPTH)) && (inflight_sum < 32'(MAX_OUT));

    assign inst_req   = resetn && pc_valid_i && credit && !flush_i;
    assign inst_addr  = pc_i;
    assign pc_ready_o = inst_req && inst_addr_ok;
    assign issue      = pc_ready_o;

    // A beat belongs to a stale request while drop is nonzero; a beat with
    // nothing in flight is a port protocol error and is ignored.
    assign drop_beat  = inst_data_ok && (drop != '0);
    assign take_beat  = inst_data_ok && (drop == '0) && (outstanding != '0);
    assign flush_beat = inst_data_ok && ((drop != '0) || (outstanding != '0));

    assign fifo_vld = (fifo_count != '0);
    assign head_pop = fifo_vld && ready_i && !flush_i;

`ifdef FETCH_BUF_BYPASS_EN
    logic bypass;

    // Empty FIFO: forward the returning beat straight to decode.
    assign bypass    = resetn && !fifo_vld && take_beat && !flush_i;
    assign valid_o   = fifo_vld || bypass;
    assign pc_o      = bypass ? tag_mem[tag_rd] : fifo_pc[rd_ptr];
    assign inst_o    = bypass ? inst_rdata      : fifo_inst[rd_ptr];
    assign fifo_push = take_beat && !(bypass && ready_i);
`else
    assign valid_o   = fifo_vld;
    assign pc_o      = fifo_pc[rd_ptr];
    assign inst_o    = fifo_inst[rd_ptr];
    assign fifo_push = take_beat;
`endif

    // Tag storage needs no reset: entries are only read behind outstanding.
    always_ff @(posedge clk) begin
        if (issue && !flush_i)
            tag_mem[tag_wr] <= pc_i;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
            outstanding <= '0;
            drop        <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc[i]   <= '0;
                fifo_inst[i] <= '0;
            end
        end else if (flush_i) begin
            // Every in-flight request becomes a drop; a beat arriving now is
            // already one of them and is swallowed immediately.
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
            outstanding <= '0;
            drop        <= drop + outstanding - OW'(flush_beat);
        end else begin
            if (issue)
                tag_wr <= tag_next(tag_wr);
            if (take_beat)
                tag_rd <= tag_next(tag_rd);
            outstanding <= outstanding + OW'(issue) - OW'(take_beat);

            if (drop_beat)
                drop <= drop - OW'(1);

            if (fifo_push) begin
                fifo_pc[wr_ptr]   <= tag_mem[tag_rd];
                fifo_inst[wr_ptr] <= inst_rdata;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (head_pop)
                rd_ptr <= rd_ptr + PW'(1);
            fifo_count <= fifo_count + CW'(fifo_push) - CW'(head_pop);
        end
    end

`ifndef SYNTHESIS
    a_no_spurious_beat: assert property (@(posedge clk) disable iff (!resetn)
        inst_data_ok |-> ((outstanding != '0) || (drop != '0)));
`endif

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// -----------------------------------------------------------------------------
// Bench for inst_fetch_buffer. The bench plays the instruction port: it keeps
// a queue of accepted requests, each marked live or stale (stale once a flush
// has happened after its acceptance). Live beats go into an expected-output
// queue which a separate monitor process pops on every decode handshake.
// -----------------------------------------------------------------------------
module tb_inst_fetch_buffer;

    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;
    localparam int AW      = 32;
    localparam int DW      = 32;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          flush_i = 1'b0;
    logic          pc_valid_i = 1'b0;
    logic [AW-1:0] pc_i = '0;
    logic          pc_ready_o;
    logic          inst_req;
    logic [AW-1:0] inst_addr;
    logic          inst_addr_ok = 1'b0;
    logic [DW-1:0] inst_rdata = '0;
    logic          inst_data_ok = 1'b0;
    logic          valid_o;
    logic [AW-1:0] pc_o;
    logic [DW-1:0] inst_o;
    logic          ready_i = 1'b0;

    inst_fetch_buffer #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .flush_i      (flush_i),
        .pc_valid_i   (pc_valid_i),
        .pc_i         (pc_i),
        .pc_ready_o   (pc_ready_o),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_rdata   (inst_rdata),
        .inst_data_ok (inst_data_ok),
        .valid_o      (valid_o),
        .pc_o         (pc_o),
        .inst_o       (inst_o),
        .ready_i      (ready_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          live;
        logic [AW-1:0] pc;
    } req_t;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] inst;
    } beat_t;

    req_t  port_q[$];
    beat_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    int p_valid, p_addr, p_data, p_ready, p_flush;
    bit rand_redirect = 1'b0;
    logic [AW-1:0] next_pc;
    logic [AW-1:0] redirect_pc;
    bit accepted = 1'b0;
    int stale_cnt = 0;

    function automatic logic [DW-1:0] inst_of(input logic [AW-1:0] pc);
        if (pc == 32'hBFC0_0380)
            return 32'h1234_5678;
        return {pc[15:0] ^ 16'h1357, pc[31:16]};
    endfunction

    function automatic bit roll(input int p);
        return int'($urandom_range(99, 0)) < p;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_mode(input int v, input int a, input int d, input int r, input int f);
        p_valid = v; p_addr = a; p_data = d; p_ready = r; p_flush = f;
    endtask

    // Drive one cycle's inputs just after the rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (flush_i)
            next_pc = redirect_pc;
        else if (accepted)
            next_pc = next_pc + 32'd4;
        flush_i = roll(p_flush);
        if (flush_i && rand_redirect)
            redirect_pc = $urandom() & 32'hFFFF_FFFC;
        pc_valid_i   = roll(p_valid);
        pc_i         = next_pc;
        inst_addr_ok = roll(p_addr);
        ready_i      = roll(p_ready);
        if (port_q.size() > 0 && roll(p_data)) begin
            inst_data_ok = 1'b1;
            if (port_q[0].live) begin
                inst_rdata = inst_of(port_q[0].pc);
            end else begin
                stale_cnt++;
                inst_rdata = 32'hDEAD_0000 + 32'(stale_cnt);
            end
        end else begin
            inst_data_ok = 1'b0;
            inst_rdata   = $urandom();
        end
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    // Reference model: request gating, head validity and the expected stream.
    initial begin
        req_t b;
        bit   exp_req, live_beat, exp_vld;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                port_q.delete();
                exp_q.delete();
                accepted = 1'b0;
                continue;
            end
            exp_req = pc_valid_i && !flush_i
                   && (exp_q.size() + port_q.size() < DEPTH)
                   && (port_q.size() < MAX_OUT);
            check("inst_req", 64'(inst_req), 64'(exp_req));
            check("pc_ready", 64'(pc_ready_o), 64'(exp_req && inst_addr_ok));
            if (inst_req)
                check("inst_addr", 64'(inst_addr), 64'(pc_i));
            live_beat = inst_data_ok && (port_q.size() > 0) && port_q[0].live && !flush_i;
`ifdef FETCH_BUF_BYPASS_EN
            exp_vld = (exp_q.size() != 0) || live_beat;
`else
            exp_vld = (exp_q.size() != 0);
`endif
            check("valid_o", 64'(valid_o), 64'(exp_vld));
            if (inst_data_ok && port_q.size() > 0) begin
                b = port_q.pop_front();
                if (live_beat)
                    exp_q.push_back({b.pc, inst_of(b.pc)});
            end
            accepted = inst_req && inst_addr_ok;
            if (accepted)
                port_q.push_back({1'b1, pc_i});
            #2;
            // Flush applies after this cycle's handshake has been checked.
            if (flush_i) begin
                exp_q.delete();
                foreach (port_q[i]) port_q[i].live = 1'b0;
            end
        end
    end

    // Monitor: every decode handshake must match the oldest expected beat.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            #1;
            if (resetn && valid_o && ready_i && !flush_i) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL head_unexpected: got pc %0h inst %0h, expected no output", pc_o, inst_o);
                end else begin
                    e = exp_q.pop_front();
                    check("pc_o", 64'(pc_o), 64'(e.pc));
                    check("inst_o", 64'(inst_o), 64'(e.inst));
                end
            end
        end
    end

    initial begin
        set_mode(0, 0, 0, 0, 0);
        next_pc     = 32'hBFC0_0000;
        redirect_pc = 32'hBFC0_0380;

        // Reset state, with a PC offered to prove inst_req is held low.
        resetn = 1'b0;
        pc_valid_i = 1'b1;
        inst_addr_ok = 1'b1;
        #12;
        check("rst_valid_o", 64'(valid_o), 64'd0);
        check("rst_inst_req", 64'(inst_req), 64'd0);
        check("rst_pc_ready", 64'(pc_ready_o), 64'd0);
        check("rst_pc_o", 64'(pc_o), 64'd0);
        check("rst_inst_o", 64'(inst_o), 64'd0);
        @(posedge clk);
        #1;
        pc_valid_i = 1'b0;
        pc_i = next_pc;
        resetn = 1'b1;

        // Streaming.
        set_mode(100, 100, 100, 100, 0);
        run(40);

        // Backpressure then release.
        set_mode(100, 100, 100, 0, 0);
        run(10);
        set_mode(100, 100, 100, 100, 0);
        run(10);

        // Flush with two requests outstanding, redirect to 0xBFC00380.
        set_mode(100, 100, 0, 100, 0);
        run(3);
        redirect_pc = 32'hBFC0_0380;
        set_mode(0, 100, 0, 100, 100);
        run(1);
        set_mode(100, 100, 100, 100, 0);
        run(12);

        // Flush coinciding with a returning beat and a pop, two outstanding.
        set_mode(100, 100, 0, 100, 0);
        run(3);
        set_mode(0, 100, 100, 0, 0);
        run(1);
        set_mode(100, 100, 0, 0, 0);
        run(1);
        redirect_pc = 32'hBFC0_1000;
        set_mode(0, 100, 100, 100, 100);
        run(1);
        set_mode(0, 100, 0, 100, 0);
        run(1);
        set_mode(100, 100, 100, 100, 0);
        run(8);

        // Random traffic with occasional flushes.
        rand_redirect = 1'b1;
        set_mode(70, 70, 50, 60, 3);
        run(2000);
        rand_redirect = 1'b0;

        // Asynchronous reset between edges with the FIFO holding entries.
        set_mode(100, 100, 100, 0, 0);
        run(5);
        @(posedge clk);
        #3;
        resetn = 1'b0;
        pc_valid_i = 1'b1;
        #1;
        check("arst_valid_o", 64'(valid_o), 64'd0);
        check("arst_inst_req", 64'(inst_req), 64'd0);
        check("arst_pc_ready", 64'(pc_ready_o), 64'd0);
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        pc_valid_i = 1'b0;
        inst_data_ok = 1'b0;
        next_pc = 32'hBFC0_0000;
        pc_i = next_pc;
        resetn = 1'b1;

        set_mode(70, 70, 50, 60, 3);
        rand_redirect = 1'b1;
        run(300);
        rand_redirect = 1'b0;

        // Drain: everything accepted must come out.
        set_mode(0, 100, 100, 100, 0);
        run(30);
        check("drain_exp_q", 64'(exp_q.size()), 64'd0);
        check("drain_port_q", 64'(port_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
